bg_trim_ctrl: RTL and testbench
===============================

Name: bg_trim_ctrl

Overview:
Digital sequencer for the bandgap core analog macro. On `start` it runs these steps in order:
- power up the core and hold its reset;
- auto-zero the comparator;
- run an 8-bit successive-approximation search on the fine current-DAC code, using the comparator output as the decision.

It then holds the core powered with the trimmed code applied. It sits between the register/control logic and the bgCore digital control inputs.

Parameters:
PWRUP_CYCLES, 256, clk cycles `pwrup` is high with `bgReset` held asserted before auto-zero.
SETTLE_CYCLES, 64, clk cycles allowed for analog settling per auto-zero phase and per SAR bit; minimum 2.
COARSE_DEFAULT, 8'h80, value driven on `idacCoarse` whenever the block is active.

Ports:
clk  input  1  block clock.
reset_n  input  1  synchronous, active-low reset.
start  input  1  single-cycle request to run a trim; ignored while busy=1.
cmpo  input  1  comparator output from the core; asynchronous; passed through a 2-flop synchroniser before use.
pwrup  output  1  core power-up enable.
bgReset  output  1  core reset, active high.
idacCoarse  output  8  coarse DAC code.
idacFine  output  8  fine DAC code (SAR trial code, then the final result).
cmpZeroOffset  output  1  comparator auto-zero enable.
cmpSwapInput  output  1  comparator input swap.
busy  output  1  high from the cycle after `start` is accepted until `done` rises.
done  output  1  level; high once a trim has completed; cleared on the next accepted `start` or on reset.
trimCode  output  8  final trim result; holds its last value until the next completion.

Behaviour:
- Reset (reset_n=0 at a clk edge) takes effect at that edge, from any state:
  - state=IDLE;
  - pwrup=0, bgReset=1;
  - idacCoarse=COARSE_DEFAULT, idacFine=8'h00;
  - cmpZeroOffset=0, cmpSwapInput=0;
  - busy=0, done=0, trimCode=8'h00;
  - all counters=0; synchroniser flops=0.
- States: IDLE, PWRUP, AZERO, SAR, FINISH, DONE. All outputs are registered.
- IDLE:
  - start=1 -> PWRUP; busy=1, done=0, pwrup=1, bgReset=1, idacFine=0.
- PWRUP:
  - counts PWRUP_CYCLES cycles, then -> AZERO with bgReset=0 and cmpZeroOffset=1.
- AZERO:
  - counts SETTLE_CYCLES cycles, then -> SAR with cmpZeroOffset=0, bit index=7, idacFine=8'h80.
- SAR, per bit i from 7 down to 0:
  - trial bit i is set in `idacFine`; wait SETTLE_CYCLES cycles.
  - On the last wait cycle, sample synchronised cmpo: 1 keeps bit i, 0 clears it.
  - In the same cycle, set bit i-1 if i>0.
  - After bit 0 -> FINISH.
- FINISH (1 cycle):
  - trimCode <= result; idacFine <= result.
  - Then -> DONE with done=1, busy=0.
- DONE:
  - pwrup stays 1 and idacFine holds the result.
  - start=1 restarts: -> PWRUP with done=0, busy=1, idacFine=0, bgReset=1.
- Latency, no chop: `done` rises PWRUP_CYCLES + 9*SETTLE_CYCLES + 2 cycles after the edge that samples `start`. It is fixed and independent of the code value.
- Edge cases:
  - start while busy: ignored, no effect.
  - start and reset_n=0 in the same cycle: reset wins.
  - Comparator always 1 -> result 8'hFF; always 0 -> result 8'h00.
  - No arithmetic overflow is possible without chop.

Optional Feature:
Macro BG_TRIM_CHOP_EN.

Defined:
- After the first SAR pass, store the result as codeA.
- Set cmpSwapInput=1, re-enter AZERO (full SETTLE_CYCLES), then run a second SAR pass. In this pass the sampled cmpo is inverted before the keep/clear decision; store codeB.
- FINISH computes trimCode = (codeA + codeB) >> 1, with a 9-bit sum, truncating.
- cmpSwapInput returns to 0 in FINISH.
- Latency increases by 9*SETTLE_CYCLES.

Undefined:
- Single pass only; cmpSwapInput is constantly 0; no codeA/codeB storage.

Test Plan:
1. PWRUP_CYCLES=8, SETTLE_CYCLES=4; comparator model cmpo=(idacFine<=100); pulse start -> trial code sequence 128,64,96,112,104,100,102,101; trimCode=100; done=1 exactly 8+36+2=46 cycles after start; pwrup=1, bgReset=0 in DONE.
2. cmpo tied 1 -> trimCode=8'hFF; cmpo tied 0 -> trimCode=8'h00; same latency in both cases.
3. Reset during SAR bit 3 -> next cycle: pwrup=0, bgReset=1, idacFine=0, busy=0, done=0; a new start runs the full sequence from PWRUP.
4. start pulsed during PWRUP and SAR -> no restart; done timing unchanged. start in DONE -> done=0 the next cycle, and the full trim repeats.
5. Check cmpZeroOffset is high exactly SETTLE_CYCLES=4 cycles and bgReset falls exactly 8 cycles after pwrup rises.
6. With BG_TRIM_CHOP_EN: model cmpo=(idacFine<=103) when swap=0, and cmpo=!(idacFine<=97) when swap=1 -> codeA=103, codeB=97, trimCode=100; cmpSwapInput=1 only during the second AZERO/SAR.

Source files
------------

// File: rtl/bg_trim_ctrl.sv
// rtl/bg_trim_ctrl.sv - bandgap trim sequencer: power-up, auto-zero, 8-bit SAR on fine DAC code
// Optional chopped two-pass trim enabled by defining BG_TRIM_CHOP_EN.
module bg_trim_ctrl #(
  parameter int          PWRUP_CYCLES   = 256,
  parameter int          SETTLE_CYCLES  = 64,
  parameter logic [7:0]  COARSE_DEFAULT = 8'h80
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       cmpo,
  output logic       pwrup,
  output logic       bgReset,
  output logic [7:0] idacCoarse,
  output logic [7:0] idacFine,
  output logic       cmpZeroOffset,
  output logic       cmpSwapInput,
  output logic       busy,
  output logic       done,
  output logic [7:0] trimCode
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PWRUP,
    S_AZERO,
    S_SAR,
    S_FINISH,
    S_DONE
  } state_t;

  localparam logic [15:0] PWRUP_LAST  = 16'(PWRUP_CYCLES - 1);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  fine_q, fine_d;
  logic [7:0]  trim_q, trim_d;
  logic [7:0]  coarse_q;
  logic        pwrup_q, pwrup_d;
  logic        bgreset_q, bgreset_d;
  logic        czo_q, czo_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        sync1_q, sync2_q;

  logic        start_ok;
  logic        decision;
  logic [7:0]  sar_code;
  logic [7:0]  result;

`ifdef BG_TRIM_CHOP_EN
  logic        pass_q, pass_d;
  logic        swap_q, swap_d;
  logic [7:0]  code_a_q, code_a_d;
  logic [8:0]  avg_sum;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      fine_q    <= 8'h00;
      trim_q    <= 8'h00;
      coarse_q  <= COARSE_DEFAULT;
      pwrup_q   <= 1'b0;
      bgreset_q <= 1'b1;
      czo_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      fine_q    <= fine_d;
      trim_q    <= trim_d;
      coarse_q  <= COARSE_DEFAULT;
      pwrup_q   <= pwrup_d;
      bgreset_q <= bgreset_d;
      czo_q     <= czo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sync1_q   <= cmpo;
      sync2_q   <= sync1_q;
    end
  end

`ifdef BG_TRIM_CHOP_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pass_q   <= 1'b0;
      swap_q   <= 1'b0;
      code_a_q <= 8'h00;
    end else begin
      pass_q   <= pass_d;
      swap_q   <= swap_d;
      code_a_q <= code_a_d;
    end
  end
`endif

  // SAR step: resolve the current bit from the comparator and raise the next trial bit.
  always_comb begin
    decision = sync2_q;
`ifdef BG_TRIM_CHOP_EN
    if (pass_q) decision = ~sync2_q;
`endif
    sar_code        = fine_q;
    sar_code[bit_q] = decision;
    if (bit_q != 3'd0) sar_code[bit_q - 3'd1] = 1'b1;
  end

`ifdef BG_TRIM_CHOP_EN
  assign avg_sum = {1'b0, code_a_q} + {1'b0, fine_q};
  assign result  = avg_sum[8:1];
`else
  assign result  = fine_q;
`endif

  assign start_ok = start && !busy_q && ((state_q == S_IDLE) || (state_q == S_DONE));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    fine_d    = fine_q;
    trim_d    = trim_q;
    pwrup_d   = pwrup_q;
    bgreset_d = bgreset_q;
    czo_d     = czo_q;
    busy_d    = busy_q;
    done_d    = done_q;
`ifdef BG_TRIM_CHOP_EN
    pass_d    = pass_q;
    swap_d    = swap_q;
    code_a_d  = code_a_q;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_ok) begin
          state_d   = S_PWRUP;
          cnt_d     = '0;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          pwrup_d   = 1'b1;
          bgreset_d = 1'b1;
          czo_d     = 1'b0;
          fine_d    = 8'h00;
`ifdef BG_TRIM_CHOP_EN
          pass_d    = 1'b0;
          swap_d    = 1'b0;
`endif
        end else if (state_q == S_DONE && !done_q) begin
          // First cycle of DONE publishes completion; start is ignored until then.
          done_d = 1'b1;
          busy_d = 1'b0;
        end
      end

      S_PWRUP: begin
        if (cnt_q == PWRUP_LAST) begin
          state_d   = S_AZERO;
          cnt_d     = '0;
          bgreset_d = 1'b0;
          czo_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      S_AZERO: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = S_SAR;
          cnt_d   = '0;
          czo_d   = 1'b0;
          bit_d   = 3'd7;
          fine_d  = 8'h80;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      S_SAR: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d  = '0;
          fine_d = sar_code;
          if (bit_q == 3'd0) begin
`ifdef BG_TRIM_CHOP_EN
            if (!pass_q) begin
              // Second pass runs with swapped comparator inputs after a fresh auto-zero.
              code_a_d = sar_code;
              pass_d   = 1'b1;
              swap_d   = 1'b1;
              czo_d    = 1'b1;
              state_d  = S_AZERO;
            end else begin
              state_d  = S_FINISH;
            end
`else
            state_d = S_FINISH;
`endif
          end else begin
            bit_d = bit_q - 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      S_FINISH: begin
        trim_d  = result;
        fine_d  = result;
        state_d = S_DONE;
`ifdef BG_TRIM_CHOP_EN
        swap_d  = 1'b0;
        pass_d  = 1'b0;
`endif
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign pwrup         = pwrup_q;
  assign bgReset       = bgreset_q;
  assign idacCoarse    = coarse_q;
  assign idacFine      = fine_q;
  assign cmpZeroOffset = czo_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign trimCode      = trim_q;
`ifdef BG_TRIM_CHOP_EN
  assign cmpSwapInput  = swap_q;
`else
  assign cmpSwapInput  = 1'b0;
`endif

endmodule

// File: tb/tb_bg_trim_ctrl.sv
// tb/tb_bg_trim_ctrl.sv - directed vector bench for bg_trim_ctrl with a threshold comparator model
module tb_bg_trim_ctrl;

  localparam int PW = 8;
  localparam int ST = 4;
`ifdef BG_TRIM_CHOP_EN
  localparam int LAT    = PW + 18 * ST + 2;
  localparam int CZO_N  = 2 * ST;
  localparam int SWAP_N = 9 * ST + 1;
  localparam bit CHOP   = 1'b1;
`else
  localparam int LAT    = PW + 9 * ST + 2;
  localparam int CZO_N  = ST;
  localparam int SWAP_N = 0;
  localparam bit CHOP   = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic       cmpo;
  logic       pwrup, bgReset, cmpZeroOffset, cmpSwapInput, busy, done;
  logic [7:0] idacCoarse, idacFine, trimCode;

  int thr_a = 100;
  int thr_b = 100;
  int n_vec = 0;
  int n_fail = 0;

  logic [7:0] fine_log[$];
  logic [7:0] last_fine = 8'h00;

  typedef struct {
    int         ta;
    int         tb;
    logic [7:0] exp_single;
    logic [7:0] exp_chop;
  } vec_t;

  bg_trim_ctrl #(
    .PWRUP_CYCLES(PW),
    .SETTLE_CYCLES(ST),
    .COARSE_DEFAULT(8'h80)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .cmpo(cmpo),
    .pwrup(pwrup),
    .bgReset(bgReset),
    .idacCoarse(idacCoarse),
    .idacFine(idacFine),
    .cmpZeroOffset(cmpZeroOffset),
    .cmpSwapInput(cmpSwapInput),
    .busy(busy),
    .done(done),
    .trimCode(trimCode)
  );

  always #5 clk = ~clk;

  always_comb begin
    if (cmpSwapInput) cmpo = !(int'(idacFine) <= thr_b);
    else              cmpo = (int'(idacFine) <= thr_a);
  end

  always @(negedge clk) begin
    if (idacFine != last_fine) begin
      last_fine = idacFine;
      if (idacFine != 8'h00) fine_log.push_back(idacFine);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_trim(input int s1, input int s2, output int lat, output int czo_n,
                          output int swap_n, output int bg_fall, output int busy0, output int done0);
    @(negedge clk);
    fine_log.delete();
    start = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    busy0  = int'(busy);
    done0  = int'(done);
    lat    = -1;
    czo_n  = 0;
    swap_n = 0;
    bg_fall = -1;
    for (int c = 1; c <= 300; c++) begin
      @(posedge clk);
      #1;
      if (cmpZeroOffset) czo_n++;
      if (cmpSwapInput) swap_n++;
      if (bg_fall < 0 && !bgReset) bg_fall = c;
      if (done) begin
        lat = c;
        break;
      end
      start = (c == s1 || c == s2);
    end
    start = 1'b0;
  endtask

  task automatic check_run(input string tag, input int s1, input int s2, input logic [7:0] exp);
    int lat, czo_n, swap_n, bg_fall, busy0, done0;
    run_trim(s1, s2, lat, czo_n, swap_n, bg_fall, busy0, done0);
    chk({tag, " latency"}, lat, LAT);
    chk({tag, " trimCode"}, int'(trimCode), int'(exp));
    chk({tag, " idacFine"}, int'(idacFine), int'(exp));
    chk({tag, " busy after start"}, busy0, 1);
    chk({tag, " done cleared"}, done0, 0);
    chk({tag, " busy in done"}, int'(busy), 0);
    chk({tag, " pwrup in done"}, int'(pwrup), 1);
    chk({tag, " bgReset in done"}, int'(bgReset), 0);
    chk({tag, " bgReset fall"}, bg_fall, PW);
    chk({tag, " azero cycles"}, czo_n, CZO_N);
    chk({tag, " swap cycles"}, swap_n, SWAP_N);
    chk({tag, " coarse"}, int'(idacCoarse), 8'h80);
  endtask

  initial begin
    vec_t vecs[7];
    logic [7:0] trial[8];
    vecs[0] = '{100, 100, 8'd100, 8'd100};
    vecs[1] = '{255, 255, 8'd255, 8'd255};
    vecs[2] = '{-1,  -1,  8'd0,   8'd0};
    vecs[3] = '{103, 97,  8'd103, 8'd100};
    vecs[4] = '{37,  200, 8'd37,  8'd118};
    vecs[5] = '{254, 255, 8'd254, 8'd254};
    vecs[6] = '{0,   1,   8'd0,   8'd0};
    trial = '{8'd128, 8'd64, 8'd96, 8'd112, 8'd104, 8'd100, 8'd102, 8'd101};

    reset_n = 1'b0;
    start   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset pwrup", int'(pwrup), 0);
    chk("reset bgReset", int'(bgReset), 1);
    chk("reset coarse", int'(idacCoarse), 8'h80);
    chk("reset fine", int'(idacFine), 0);
    chk("reset czo", int'(cmpZeroOffset), 0);
    chk("reset swap", int'(cmpSwapInput), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset trimCode", int'(trimCode), 0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      thr_a = vecs[i].ta;
      thr_b = vecs[i].tb;
      check_run($sformatf("vec%0d", i), -1, -1, CHOP ? vecs[i].exp_chop : vecs[i].exp_single);
      if (i == 0) begin
        chk("trial count", fine_log.size() >= 8 ? 1 : 0, 1);
        for (int k = 0; k < 8 && k < fine_log.size(); k++)
          chk($sformatf("trial code %0d", k), int'(fine_log[k]), int'(trial[k]));
      end
    end

    // start pulses while busy must not disturb the sequence
    @(negedge clk);
    thr_a = 100;
    thr_b = 100;
    check_run("busy start", 3, 20, 8'd100);

    // reset during SAR bit 3, with start asserted alongside reset
    @(negedge clk);
    thr_a = 37;
    thr_b = 37;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (29) @(posedge clk);
    #1;
    reset_n = 1'b0;
    start   = 1'b1;
    @(posedge clk);
    #1;
    chk("midrun reset pwrup", int'(pwrup), 0);
    chk("midrun reset bgReset", int'(bgReset), 1);
    chk("midrun reset fine", int'(idacFine), 0);
    chk("midrun reset busy", int'(busy), 0);
    chk("midrun reset done", int'(done), 0);
    chk("midrun reset trimCode", int'(trimCode), 0);
    @(negedge clk);
    reset_n = 1'b1;
    start   = 1'b0;
    @(negedge clk);
    chk("idle after reset busy", int'(busy), 0);
    chk("idle after reset pwrup", int'(pwrup), 0);
    check_run("after reset", -1, -1, 8'd37);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
